// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types: instruction size, fetch-queue entry, jump kinds
package core_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    typedef enum logic [2:0] {
        JUMP_NOP,
        JUMP_BEQ,
        JUMP_JAL,
        JUMP_JR,
        JUMP_J
    } jump_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch queue with flush, occupancy count and register-file head
module fetch_fifo import core_pkg::*; #(
    parameter type entry_t = fq_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output entry_t                     head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push    = push && (count != CW'(DEPTH));
    assign do_pop     = pop && (count != '0);
    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush drops everything, including a push or pop landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction fetch front end; FETCH_PERF_EN builds the perf counters
module fetch_unit import core_pkg::*; #(
    parameter int               DWIDTH    = 32,
    parameter int               FQ_DEPTH  = 4,
    parameter int               MAX_OUTST = 2,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [DWIDTH-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DWIDTH-1:0] instr_data,
    output logic [DWIDTH-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [DWIDTH-1:0] redirect_pc,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_redirects
);

    typedef struct packed {
        logic [DWIDTH-1:0] pc;
        logic [DWIDTH-1:0] instr;
    } entry_t;

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [DWIDTH-1:0] fetch_pc;
    logic [DWIDTH-1:0] rsp_pc;
    logic [DWIDTH-1:0] target_pc;
    logic [OW-1:0]     outst;
    logic [OW-1:0]     outst_next;
    logic [OW-1:0]     drop;
    logic [CW-1:0]     fq_count;
    logic              accept;
    logic              push;
    logic              pop;
    logic              head_valid;
    entry_t            head;

    // Credit: every live (non-dropped) request already owns a queue slot, so the queue never overflows.
    assign imem_req_valid = !rst && !redirect_valid && (int'(outst) < MAX_OUTST)
                            && (int'(outst - drop) + int'(fq_count) < FQ_DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign outst_next     = outst + OW'(accept) - OW'(imem_rsp_valid);
    assign push           = imem_rsp_valid && (drop == '0);
    assign target_pc      = redirect_pc & ~DWIDTH'(3);

    assign instr_valid = head_valid && !rst;
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;
    assign pop         = instr_valid && instr_ready;

    // rsp_pc tracks the fetch PC of the oldest live request; responses return in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            outst    <= '0;
            drop     <= '0;
        end else begin
            outst <= outst_next;
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop     <= outst_next;
            end else begin
                if (accept)                              fetch_pc <= fetch_pc + DWIDTH'(INSTR_BYTES);
                if (push)                                rsp_pc   <= rsp_pc + DWIDTH'(INSTR_BYTES);
                if (imem_rsp_valid && (drop != '0))      drop     <= drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FQ_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  ('{pc: rsp_pc, instr: imem_rsp_data}),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .head_valid (head_valid),
        .count      (fq_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] redirects_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q   <= '0;
            redirects_q <= '0;
        end else begin
            if (pop)            fetched_q   <= fetched_q + 32'd1;
            if (redirect_valid) redirects_q <= redirects_q + 32'd1;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_redirects = redirects_q;
`else
    assign perf_fetched   = '0;
    assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;

`ifdef FETCH_PERF_EN
    localparam logic [31:0] EXP_FETCHED   = 32'd10;
    localparam logic [31:0] EXP_REDIRECTS = 32'd2;
`else
    localparam logic [31:0] EXP_FETCHED   = 32'd0;
    localparam logic [31:0] EXP_REDIRECTS = 32'd0;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rq_t;

    rq_t         mq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          pops = 0;
    int          first_pop_cyc = -1;
    int          rr_pct = 100;
    int          ir_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_pc = '0;
    logic [31:0] last_pc = '0;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, settle, record handshakes the coming posedge will commit.
    task automatic step(input logic rv, input logic [31:0] rpc);
        int pre;
        int due;
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(99) < rr_pct);
        instr_ready    = ($urandom_range(99) < ir_pct);
        pre = mq.size();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mk(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            check_eq("outst_limit", 32'(pre < 2), 32'd1);
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_req_addr, due: due});
        end
        if (instr_valid && instr_ready) begin
            check_eq("deliver_pc", instr_pc, exp_pc);
            check_eq("deliver_data", instr_data, mk(exp_pc));
            exp_pc  = exp_pc + 32'd4;
            last_pc = instr_pc;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            pops++;
        end
        if (rv) exp_pc = rpc & ~32'd3;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        mq.delete();
        exp_pc        = '0;
        first_pop_cyc = -1;
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        cyc++;
        last_due = cyc;
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp);
        int p0;
        int n;
        p0 = pops;
        n  = 0;
        while (pops == p0 && n < 40) begin
            step(1'b0, '0);
            n++;
        end
        check_eq({tag, "_arrived"}, 32'(pops != p0), 32'd1);
        check_eq(tag, last_pc, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int p0;
        int n;

        // Stream at latency 1
        do_reset();
        check_eq("rst_addr", imem_req_addr, 32'h0);
        c0 = cyc;
        for (int i = 0; i < 12; i++) step(1'b0, '0);
        check_eq("first_pop_cycle", 32'(first_pop_cyc - c0), 32'd2);
        check_eq("stream_pops", 32'(pops), 32'd10);

        // Backpressure: queue fills to 4, requests stop, then drains exactly 4
        ir_pct = 0;
        p0 = pops;
        for (int i = 0; i < 20; i++) step(1'b0, '0);
        check_eq("bp_no_pop", 32'(pops - p0), 32'd0);
        check_eq("bp_req_stopped", 32'(imem_req_valid), 32'd0);
        check_eq("bp_none_inflight", 32'(mq.size()), 32'd0);
        rr_pct = 0;
        ir_pct = 100;
        p0 = pops;
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        check_eq("bp_drain4", 32'(pops - p0), 32'd4);
        rr_pct = 100;
        for (int i = 0; i < 8; i++) step(1'b0, '0);

        // Redirect with two requests in flight
        lat_min = 3;
        lat_max = 3;
        do_reset();
        step(1'b0, '0);
        step(1'b0, '0);
        check_eq("two_inflight", 32'(mq.size()), 32'd2);
        step(1'b1, 32'h100);
        wait_pop("redir_first", 32'h100);
        wait_pop("redir_second", 32'h104);

        // Back-to-back redirects: last one wins
        step(1'b1, 32'h40);
        step(1'b1, 32'h80);
        step(1'b1, 32'hC0);
        wait_pop("b2b_first", 32'hC0);
        wait_pop("b2b_second", 32'hC4);
        for (int i = 0; i < 10; i++) step(1'b0, '0);
        check_eq("drop_zero", 32'(dut.drop), 32'd0);

        // Unaligned redirect near the top of the address space; PC wraps
        step(1'b1, 32'hFFFF_FFFA);
        wait_pop("wrap_f8", 32'hFFFF_FFF8);
        wait_pop("wrap_fc", 32'hFFFF_FFFC);
        wait_pop("wrap_0", 32'h0);

        // Random latency, request stalls, decode stalls, occasional redirects
        lat_min = 1;
        lat_max = 5;
        rr_pct  = 70;
        ir_pct  = 70;
        do_reset();
        p0 = pops;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 3) step(1'b1, $urandom & ~32'd3);
            else                        step(1'b0, '0);
        end
        check_eq("rand_progress", 32'(pops - p0 > 50), 32'd1);

        // Performance counters: 10 deliveries, 2 redirects
        lat_min = 1;
        lat_max = 1;
        rr_pct  = 0;
        ir_pct  = 0;
        do_reset();
        step(1'b0, '0);
        check_eq("perf_rst_fetched", perf_fetched, 32'd0);
        check_eq("perf_rst_redirects", perf_redirects, 32'd0);
        rr_pct = 100;
        ir_pct = 100;
        p0 = pops;
        n  = 0;
        while (pops - p0 < 10 && n < 50) begin
            step(1'b0, '0);
            n++;
        end
        check_eq("perf_ten_pops", 32'(pops - p0), 32'd10);
        ir_pct = 0;
        step(1'b1, 32'h200);
        step(1'b1, 32'h300);
        step(1'b0, '0);
        check_eq("perf_fetched", perf_fetched, EXP_FETCHED);
        check_eq("perf_redirects", perf_redirects, EXP_REDIRECTS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
